// File: rtl/ladybird_bus_unit_if.sv
// AXI4 master/slave bundle used by the ladybird bus unit.
// Single-beat transactions only; IDs are carried but not decoded.
interface ladybird_axi_interface #(
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 4
);
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ladybird_bus_unit.sv
// Round-robin fetch/data arbiter onto one AXI master, one transaction
// in flight, with byte-lane steering for buses wider than 32 bits.
module ladybird_bus_unit #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 32,
  parameter int ID_I   = 0,
  parameter int ID_D   = 1,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic [XLEN-1:0] inst,
  output logic            inst_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_we,
  input  logic [2:0]      i_funct,
  input  logic            i_valid,
  output logic            i_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_err,
  output logic            o_valid,
  input  logic            o_ready,
  ladybird_axi_interface.master axi
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SIZE = (OFFW > 2) ? 2 : OFFW;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AWW, S_B, S_ERR
  } state_t;

  state_t          state_q;
  logic            gnt_d_q;
  logic            id_d_q;
  logic            we_q;
  logic [2:0]      funct_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic            awvalid_q;
  logic            wvalid_q;

  logic            idle, acc_i, acc_d, rsp_rdy;
  logic            n_we, n_mis;
  logic [2:0]      n_funct;
  logic [XLEN-1:0] n_addr;
  logic [OFFW-1:0] off;
  logic [DATA_W-1:0] rsh;
  logic [31:0]     word, ld, rd_val;
  logic [NB-1:0]   base;
  logic            in_r, in_b, in_e;

  function automatic logic misal(input logic [2:0] f,
                                 input logic [1:0] a);
    return (f[1:0] == 2'b01 && a[0]) ||
           (f[1:0] == 2'b10 && a != 2'b00);
  endfunction

  assign idle     = (state_q == S_IDLE);
  assign pc_ready = idle & (~i_valid | gnt_d_q);
  assign i_ready  = idle & (~pc_valid | ~gnt_d_q);
  assign acc_i    = pc_valid & pc_ready;
  assign acc_d    = i_valid & i_ready;

  // fetches are word loads
  assign n_funct = acc_i ? 3'b010 : i_funct;
  assign n_addr  = acc_i ? pc : i_addr;
  assign n_we    = acc_d & i_we;
  assign n_mis   = misal(n_funct, n_addr[1:0]);

  assign rsp_rdy = id_d_q ? o_ready : inst_ready;
  assign off     = addr_q[OFFW-1:0];
  assign rsh     = axi.rdata >> {off, 3'b000};
  assign word    = rsh[31:0];

  always_comb begin
    ld = word;
    unique case (funct_q)
      3'b000:  ld = {{24{word[7]}}, word[7:0]};
      3'b001:  ld = {{16{word[15]}}, word[15:0]};
      3'b100:  ld = {24'h0, word[7:0]};
      3'b101:  ld = {16'h0, word[15:0]};
      default: ld = word;
    endcase
  end

  assign rd_val = axi.rresp[1] ? 32'h0 : ld;

  assign in_r = (state_q == S_R) & axi.rvalid;
  assign in_b = (state_q == S_B) & axi.bvalid;
  assign in_e = (state_q == S_ERR);

  assign inst_valid = ~id_d_q & (in_r | in_e);
  assign inst_err   = ~id_d_q & ((in_r & axi.rresp[1]) | in_e);
  assign inst       = (~id_d_q & in_r) ? rd_val : '0;

  assign o_valid = id_d_q & (in_r | in_b | in_e);
  assign o_err   = id_d_q & ((in_r & axi.rresp[1]) |
                             (in_b & axi.bresp[1]) | in_e);
  assign o_data  = (id_d_q & in_r) ? rd_val : '0;

  assign axi.arid    = id_d_q ? ID_W'(ID_D) : ID_W'(ID_I);
  assign axi.araddr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state_q == S_AR);
  assign axi.rready  = (state_q == S_R) & rsp_rdy;

  assign axi.awid    = axi.arid;
  assign axi.awaddr  = axi.araddr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'(SIZE);
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = (state_q == S_B) & o_ready;

  always_comb begin
    base      = NB'(4'hF);
    axi.wdata = {(NB/4){data_q}};
    unique case (funct_q[1:0])
      2'b00: begin
        base      = NB'(4'h1);
        axi.wdata = {NB{data_q[7:0]}};
      end
      2'b01: begin
        base      = NB'(4'h3);
        axi.wdata = {(NB/2){data_q[15:0]}};
      end
      default: begin
        base      = NB'(4'hF);
        axi.wdata = {(NB/4){data_q}};
      end
    endcase
  end

  assign axi.wstrb = base << off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_d_q   <= 1'b1;
      id_d_q    <= 1'b0;
      we_q      <= 1'b0;
      funct_q   <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (acc_i | acc_d) begin
            gnt_d_q <= acc_d;
            id_d_q  <= acc_d;
            we_q    <= n_we;
            funct_q <= n_funct;
            addr_q  <= n_addr;
            data_q  <= i_data;
            if (n_mis) begin
              state_q <= S_ERR;
            end else if (n_we) begin
              state_q   <= S_AWW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q <= S_AR;
            end
          end
        end
        S_AR: if (axi.arready) state_q <= S_R;
        S_R: begin
          if (axi.rvalid & rsp_rdy & axi.rlast)
            state_q <= S_IDLE;
        end
        S_AWW: begin
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if ((~awvalid_q | axi.awready) &
              (~wvalid_q | axi.wready))
            state_q <= S_B;
        end
        S_B:   if (axi.bvalid & o_ready) state_q <= S_IDLE;
        S_ERR: if (rsp_rdy) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = we_q;
endmodule

// File: tb/tb_ladybird_bus_unit.sv
// Directed bench for ladybird_bus_unit on a 64-bit bus, checked
// against a byte-level model of loads, stores and alignment.
module tb_ladybird_bus_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic [31:0] inst;
  logic        inst_err, inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] i_addr = '0, i_data = '0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct = '0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_err, o_valid;
  logic        o_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  ladybird_axi_interface #(.AXI_DATA_W(64)) axi ();

  ladybird_bus_unit #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .inst(inst), .inst_err(inst_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
    .i_funct(i_funct), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_err(o_err),
    .o_valid(o_valid), .o_ready(o_ready),
    .axi(axi.master)
  );

  always #5 clk = ~clk;

  // current transaction as the bench sees it
  bit          cur_isI, cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_funct;
  logic [63:0] cur_rdata;
  logic [1:0]  cur_rresp, cur_bresp;

  logic        cap_valid, cap_err;
  logic [31:0] cap_data;
  logic [31:0] cap_awaddr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_nb(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [31:0] a,
                               input logic [2:0] f);
    return (a % m_nb(f)) != 0;
  endfunction

  function automatic logic [31:0] m_line(input logic [31:0] a);
    return a - (a % 8);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a,
      input logic [2:0] f, input logic [63:0] bus);
    logic [7:0] b [8];
    int o;
    for (int i = 0; i < 8; i++) b[i] = bus[8*i +: 8];
    o = a % 8;
    case (f)
      3'b000:  return {{24{b[o][7]}}, b[o]};
      3'b100:  return {24'h0, b[o]};
      3'b001:  return {{16{b[o+1][7]}}, b[o+1], b[o]};
      3'b101:  return {16'h0, b[o+1], b[o]};
      default: return {b[o+3], b[o+2], b[o+1], b[o]};
    endcase
  endfunction

  function automatic logic [7:0] m_strb(input logic [31:0] a,
                                        input logic [2:0] f);
    logic [7:0] s;
    int o;
    o = a % 8;
    for (int i = 0; i < 8; i++)
      s[i] = (i >= o) && (i < o + m_nb(f));
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [31:0] d,
                                          input logic [2:0] f);
    logic [63:0] w;
    for (int i = 0; i < 8; i++)
      w[8*i +: 8] = d[8*(i % m_nb(f)) +: 8];
    return w;
  endfunction

  function automatic bit m_err();
    if (m_mis(cur_addr, cur_funct)) return 1'b1;
    return cur_we ? cur_bresp[1] : cur_rresp[1];
  endfunction

  function automatic logic [31:0] m_data();
    if (cur_we || m_err()) return 32'h0;
    return m_load(cur_addr, cur_funct, cur_rdata);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (axi.arvalid) begin
        chk("ar_legal",
            64'(cur_we || m_mis(cur_addr, cur_funct)), 0);
        chk("araddr", axi.araddr, m_line(cur_addr));
        chk("arid", axi.arid, cur_isI ? 0 : 1);
        chk("arsize", axi.arsize, 2);
        chk("arlen", axi.arlen, 0);
      end
      if (axi.awvalid) begin
        chk("aw_legal",
            64'(!cur_we || m_mis(cur_addr, cur_funct)), 0);
        chk("awaddr", axi.awaddr, m_line(cur_addr));
        chk("awsize", axi.awsize, 2);
      end
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, m_wdata(cur_wdata, cur_funct));
        chk("wstrb", axi.wstrb, m_strb(cur_addr, cur_funct));
        chk("wlast", axi.wlast, 1);
      end
      if (axi.rvalid)
        chk("rready", axi.rready,
            cur_isI ? inst_ready : o_ready);
      if (axi.bvalid) chk("bready", axi.bready, o_ready);
      if (inst_valid) begin
        chk("inst_port", 64'(cur_isI), 1);
        chk("inst_err", inst_err, m_err());
        chk("inst", inst, m_data());
      end
      if (o_valid) begin
        chk("o_port", 64'(cur_isI), 0);
        chk("o_err", o_err, m_err());
        chk("o_data", o_data, m_data());
      end
    end
  end

  task automatic set_cur(input bit isI, input logic [31:0] a,
      input logic [2:0] f, input bit we, input logic [31:0] wd,
      input logic [63:0] rd, input logic [1:0] rr,
      input logic [1:0] br);
    cur_isI   = isI;
    cur_addr  = a;
    cur_funct = isI ? 3'b010 : f;
    cur_we    = we && !isI;
    cur_wdata = wd;
    cur_rdata = rd;
    cur_rresp = rr;
    cur_bresp = br;
  endtask

  task automatic req(input bit isI, input logic [31:0] a,
      input logic [2:0] f, input bit we, input logic [31:0] wd,
      input logic [63:0] rd, input logic [1:0] rr,
      input logic [1:0] br);
    int n = 0;
    set_cur(isI, a, f, we, wd, rd, rr, br);
    if (isI) begin
      pc = a; pc_valid = 1'b1;
    end else begin
      i_addr = a; i_funct = f; i_we = we;
      i_data = wd; i_valid = 1'b1;
    end
    @(negedge clk);
    while (!(isI ? pc_ready : i_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    if (isI) pc_valid = 1'b0;
    else i_valid = 1'b0;
  endtask

  task automatic set_rdy(input bit v);
    if (cur_isI) inst_ready = v;
    else o_ready = v;
  endtask

  task automatic capture();
    cap_valid = cur_isI ? inst_valid : o_valid;
    cap_err   = cur_isI ? inst_err : o_err;
    cap_data  = cur_isI ? inst : o_data;
  endtask

  task automatic serve_read(input int stall);
    int n = 0;
    @(negedge clk);
    chk("ar_latency", axi.arvalid, 1);
    while (!axi.arvalid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      chk("ar_timeout", 1, 0);
      return;
    end
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    axi.rdata = cur_rdata;
    axi.rresp = cur_rresp;
    axi.rlast = 1'b1;
    axi.rvalid = 1'b1;
    repeat (stall) begin
      set_rdy(1'b0);
      @(negedge clk);
      chk("stall_rready", axi.rready, 0);
      chk("stall_valid", cur_isI ? inst_valid : o_valid, 1);
      @(posedge clk); #1;
    end
    set_rdy(1'b1);
    n = 0;
    @(negedge clk);
    while (!axi.rready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("r_timeout", 1, 0);
    capture();
    @(posedge clk); #1;
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
  endtask

  task automatic serve_write(input int awdel, input int wdel);
    bit awd = 0, wd = 0, haw, hw;
    int c = 0, n = 0;
    while (!(awd && wd) && c < 30) begin
      axi.awready = (c >= awdel);
      axi.wready  = (c >= wdel);
      @(negedge clk);
      if (awd) chk("awvalid_drop", axi.awvalid, 0);
      if (wd) chk("wvalid_drop", axi.wvalid, 0);
      if (!awd) chk("bready_early", axi.bready, 0);
      if (axi.awvalid) cap_awaddr = axi.awaddr;
      if (axi.wvalid) begin
        cap_wdata = axi.wdata;
        cap_wstrb = axi.wstrb;
      end
      haw = axi.awvalid && axi.awready;
      hw  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      awd |= haw;
      wd |= hw;
      c++;
    end
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    if (c >= 30) chk("aw_w_timeout", 1, 0);
    axi.bresp = cur_bresp;
    axi.bvalid = 1'b1;
    @(negedge clk);
    while (!axi.bready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("b_timeout", 1, 0);
    capture();
    @(posedge clk); #1;
    axi.bvalid = 1'b0;
  endtask

  task automatic serve_err(input int stall);
    repeat (stall) begin
      set_rdy(1'b0);
      @(negedge clk);
      chk("err_hold", cur_isI ? inst_valid : o_valid, 1);
      chk("err_no_axi", axi.arvalid | axi.awvalid, 0);
      @(posedge clk); #1;
    end
    set_rdy(1'b1);
    @(negedge clk);
    chk("err_no_axi", axi.arvalid | axi.awvalid, 0);
    capture();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] d,
                     input bit e);
    chk({nm, "_valid"}, cap_valid, 1);
    chk({nm, "_err"}, cap_err, e);
    chk({nm, "_data"}, cap_data, d);
  endtask

  localparam logic [63:0] RD0 = 64'h1111_2222_3333_4444;

  initial begin
    bit last_d;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0;
    axi.rresp = 0; axi.rlast = 0; axi.rid = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    axi.bresp = 0; axi.bid = '0;
    set_cur(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_errs", {o_err, inst_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // tie-break: fetch, then data, then fetch again
    pc = 32'h2000; pc_valid = 1'b1;
    i_addr = 32'h1004; i_funct = 3'b010; i_we = 1'b0;
    i_valid = 1'b1;
    last_d = 1'b1;
    for (int r = 0; r < 3; r++) begin
      if (last_d) set_cur(1, 32'h2000, 3'b010, 0, 0, RD0, 0, 0);
      else set_cur(0, 32'h1004, 3'b010, 0, 0, RD0, 0, 0);
      @(negedge clk);
      chk("tie_pc_ready", pc_ready, last_d);
      chk("tie_i_ready", i_ready, !last_d);
      @(posedge clk); #1;
      if (last_d) pc_valid = 1'b0;
      else i_valid = 1'b0;
      last_d = !last_d;
      serve_read(0);
      lit("tie", (r == 1) ? 32'h1111_2222 : 32'h3333_4444, 0);
      pc_valid = 1'b1;
      i_valid = 1'b1;
    end
    pc_valid = 1'b0;
    i_valid = 1'b0;

    req(0, 32'h1005, 3'b000, 0, 0, 64'h0000_8000_0000_0000, 0, 0);
    serve_read(0);
    lit("lb", 32'hFFFF_FF80, 0);
    req(0, 32'h1005, 3'b100, 0, 0, 64'h0000_8000_0000_0000, 0, 0);
    serve_read(1);
    lit("lbu", 32'h0000_0080, 0);
    req(0, 32'h1006, 3'b001, 0, 0, 64'h8001_0000_0000_0000, 0, 0);
    serve_read(0);
    lit("lh", 32'hFFFF_8001, 0);
    req(0, 32'h1006, 3'b101, 0, 0, 64'h8001_0000_0000_0000, 0, 0);
    serve_read(0);
    lit("lhu", 32'h0000_8001, 0);

    req(0, 32'h1006, 3'b001, 1, 32'h0000_BEEF, 0, 0, 0);
    serve_write(0, 0);
    chk("sh_awaddr", cap_awaddr, 32'h1000);
    chk("sh_wstrb", cap_wstrb, 8'hC0);
    chk("sh_wdata", cap_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    lit("sh", 0, 0);

    req(0, 32'h100C, 3'b010, 1, 32'hDEAD_BEEF, 0, 0, 0);
    serve_write(3, 0);
    chk("sw_wstrb", cap_wstrb, 8'hF0);
    chk("sw_wdata", cap_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    lit("sw", 0, 0);

    req(0, 32'h1003, 3'b000, 1, 32'h1234_565A, 0, 0, 2'b10);
    serve_write(2, 1);
    chk("sb_wstrb", cap_wstrb, 8'h08);
    chk("sb_wdata", cap_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
    lit("sb_berr", 0, 1);

    req(0, 32'h1002, 3'b010, 0, 0, RD0, 0, 0);
    serve_err(2);
    lit("lw_mis", 0, 1);
    req(0, 32'h1001, 3'b001, 1, 32'h0000_1234, 0, 0, 0);
    serve_err(0);
    lit("sh_mis", 0, 1);
    req(1, 32'h2002, 3'b010, 0, 0, RD0, 0, 0);
    serve_err(1);
    lit("fetch_mis", 0, 1);

    req(1, 32'h2008, 3'b010, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD,
        2'b10, 0);
    serve_read(2);
    lit("fetch_rerr", 0, 1);
    req(1, 32'h200C, 3'b010, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    serve_read(0);
    lit("fetch_hi", 32'h0123_4567, 0);
    req(0, 32'h1000, 3'b010, 0, 0, RD0, 2'b10, 0);
    serve_read(0);
    lit("lw_rerr", 0, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
